// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: arbiter FSM states,
// byte width and the ASCII characters the requester sequencers emit.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [UART_DATA_W-1:0] CH_AT    = 8'h40;
  localparam logic [UART_DATA_W-1:0] CH_ZERO  = 8'h30;
  localparam logic [UART_DATA_W-1:0] CH_SLASH = 8'h2F;
  localparam logic [UART_DATA_W-1:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_e;

  // Increment with wrap to zero at n; n need not be a power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and the UART
// transmitter. master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_start;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin search: lowest index at or after ptr_i (wrapping)
// whose valid bit is set, as both a one-hot vector and a binary index.
module rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  int             j;
  logic [IDX_W-1:0] j_idx;

  // Walk from the farthest offset down so the nearest valid entry wins last.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    j        = 0;
    j_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (valid_i[j_idx]) begin
        idx_o   = j_idx;
        found_o = 1'b1;
      end
    end
    onehot_o[idx_o] = found_o;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers; one frame in flight at a time, tracked through tx_busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 8,
  parameter  int BUSY_TIMEOUT = 7,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.master  bus,
  output logic [IDX_W-1:0]   grant_id,
  output logic               active,
  output logic               timeout_err
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] ready;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .valid_i  (bus.req_valid),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .found_o  (win_found)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    ready      = '0;
    case (state_q)
      ST_IDLE: begin
        // A frame still running (e.g. across reset) blocks any new grant.
        if (!bus.tx_busy) begin
          ready = win_onehot;
          if (win_found) begin
            tx_data_d  = req_bytes[win_idx];
            grant_d    = win_idx;
            ptr_d      = IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
            tx_start_d = 1'b1;
            state_d    = ST_START;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(BUSY_TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_q;
  assign active        = (state_q != ST_IDLE);
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: requester queues, a busy
// model for the transmitter and a monitor that checks every tx_start.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] grant_id;
  logic       active;
  logic       timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(8), .BUSY_TIMEOUT(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  typedef struct { logic [1:0] g; logic [7:0] d; } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [7:0] rq [NR][$];
  int   acc_cnt [NR];
  int   consumed [NR];
  int   acc_log[$], start_log[$], to_log[$], fall_log[$];
  logic [7:0] tx_log[$];

  bit   auto_busy = 1'b1;
  bit   man_busy  = 1'b0;
  bit   auto_q    = 1'b0;
  assign bus.tx_busy = auto_busy ? auto_q : man_busy;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    start_log.delete();
    to_log.delete();
    fall_log.delete();
    tx_log.delete();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0) && !active && !bus.tx_busy;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (k < budget && !all_idle()) begin
      step(1);
      k++;
    end
    chk(name, 64'(k < budget), 64'd1);
    step(2);
  endtask

  // Requesters: present queue heads, pop once the monitor saw the handshake.
  task automatic requester_loop();
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (acc_cnt[i] != consumed[i]) begin
          consumed[i] = acc_cnt[i];
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
        bus.req_valid[i]      = (rq[i].size() > 0);
        bus.req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
    end
  endtask

  // Transmitter model: busy rises on the WAIT_BUSY entry edge, lasts 10 cycles.
  task automatic busy_loop();
    bit start_seen = 1'b0;
    int busy_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start_seen) begin
        busy_left  = 10;
        start_seen = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (bus.tx_start) start_seen = 1'b1;
      auto_q = (busy_left > 0);
    end
  endtask

  task automatic monitor_loop();
    bit   prev_b = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (|bus.req_ready) chk("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
      if (rst_n) begin
        for (int i = 0; i < NR; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            acc_cnt[i]++;
            acc_log.push_back(cyc);
          end
        end
      end
      if (bus.tx_start) begin
        $display("tx cyc=%0d grant=%0d data=%02h", cyc, grant_id, bus.tx_data);
        start_log.push_back(cyc);
        tx_log.push_back(bus.tx_data);
        if (acc_log.size() > 0) chk("start_latency", 64'(cyc - acc_log[$]), 64'd1);
        else chk("start_without_accept", 64'd0, 64'd1);
        if (sb.size() == 0) begin
          chk("spurious_start", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("tx_data", 64'(bus.tx_data), 64'(e.d));
          chk("grant_id", 64'(grant_id), 64'(e.g));
        end
      end
      if (timeout_err) begin
        to_log.push_back(cyc);
        chk("timeout_active", 64'(active), 64'd0);
      end
      if (prev_b && !bus.tx_busy) fall_log.push_back(cyc);
      prev_b = bus.tx_busy;
    end
  endtask

  initial begin
    int   drop_cyc;
    bit   seen_ready;
    logic [39:0] stream;

    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      acc_cnt[i]  = 0;
      consumed[i] = 0;
    end
    fork
      requester_loop();
      busy_loop();
      monitor_loop();
    join_none

    // Reset state
    step(2);
    @(negedge clk);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_tx_start", 64'(bus.tx_start), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'h00);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    step(1);
    rst_n = 1'b1;

    // Single requester, two bytes, minimum turnaround after busy falls
    clear_logs();
    rq[0].push_back(CH_AT);
    rq[0].push_back(CH_ZERO);
    expect_tx(2'd0, CH_AT);
    expect_tx(2'd0, CH_ZERO);
    drain("t1_drain", 200);
    chk("t1_accepts", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2 && fall_log.size() >= 1)
      chk("t1_turnaround", 64'(acc_log[1] - fall_log[0]), 64'd1);

    // All four requesters valid: order 0,1,2,3,0
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    clear_logs();
    rq[0].push_back(CH_AT);
    rq[0].push_back(CH_AT);
    rq[1].push_back(CH_ZERO);
    rq[2].push_back(CH_SLASH);
    rq[3].push_back(CH_LF);
    expect_tx(2'd0, 8'h40);
    expect_tx(2'd1, 8'h30);
    expect_tx(2'd2, 8'h2F);
    expect_tx(2'd3, 8'h0A);
    expect_tx(2'd0, 8'h40);
    drain("t2_drain", 400);
    chk("t2_count", 64'(tx_log.size()), 64'd5);
    if (tx_log.size() == 5) begin
      stream = {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]};
      chk("t2_stream", 64'(stream), 64'h40302F0A40);
    end

    // Busy never rises: timeout, pointer kept (requester 1 then 0)
    auto_busy = 1'b0;
    man_busy  = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    clear_logs();
    rq[0].push_back(CH_AT);
    expect_tx(2'd0, 8'h40);
    drain("t3_drain_a", 100);
    chk("t3_timeouts_a", 64'(to_log.size()), 64'd1);
    if (to_log.size() == 1 && start_log.size() == 1)
      chk("t3_timeout_delay", 64'(to_log[0] - start_log[0]), 64'd8);
    rq[0].push_back(CH_LF);
    rq[1].push_back(CH_ZERO);
    expect_tx(2'd1, 8'h30);
    expect_tx(2'd0, 8'h0A);
    drain("t3_drain_b", 200);
    chk("t3_timeouts_b", 64'(to_log.size()), 64'd3);
    if (to_log.size() == 3 && start_log.size() == 3)
      for (int k = 1; k < 3; k++) chk("t3_timeout_delay_b", 64'(to_log[k] - start_log[k]), 64'd8);

    // Busy already high at reset release with requester 2 waiting
    rst_n = 1'b0;
    man_busy = 1'b1;
    clear_logs();
    rq[2].push_back(CH_SLASH);
    expect_tx(2'd2, 8'h2F);
    step(2);
    rst_n = 1'b1;
    seen_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (|bus.req_ready) seen_ready = 1'b1;
    end
    chk("t4_no_ready_while_busy", 64'(seen_ready), 64'd0);
    step(1);
    man_busy  = 1'b0;
    auto_busy = 1'b1;
    drop_cyc  = cyc;
    drain("t4_drain", 200);
    chk("t4_accepts", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() >= 1) chk("t4_accept_cyc", 64'(acc_log[0]), 64'(drop_cyc));

    // Reset during WAIT_DONE: pointer back to 0, byte discarded
    clear_logs();
    rq[1].push_back(CH_ZERO);
    expect_tx(2'd1, 8'h30);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(active && bus.tx_busy) && k < 50);
      chk("t5_reach_busy", 64'(k < 50), 64'd1);
    end
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_active", 64'(active), 64'd0);
    chk("t5_tx_start", 64'(bus.tx_start), 64'd0);
    chk("t5_tx_data", 64'(bus.tx_data), 64'h00);
    chk("t5_grant_id", 64'(grant_id), 64'd0);
    chk("t5_timeout", 64'(timeout_err), 64'd0);
    step(1);
    rq[0].push_back(CH_AT);
    rq[2].push_back(CH_SLASH);
    expect_tx(2'd0, 8'h40);
    expect_tx(2'd2, 8'h2F);
    drain("t5_drain", 300);

    // Requester 3 withdraws before grant; requester 1 wins despite pointer at 3
    clear_logs();
    auto_busy = 1'b0;
    man_busy  = 1'b1;
    rq[3].push_back(CH_LF);
    rq[1].push_back(CH_ZERO);
    expect_tx(2'd1, 8'h30);
    step(3);
    @(negedge clk);
    chk("t6_ready_held", 64'(bus.req_ready), 64'd0);
    step(1);
    rq[3].delete();
    step(1);
    man_busy  = 1'b0;
    auto_busy = 1'b1;
    drain("t6_drain", 200);
    chk("t6_starts", 64'(start_log.size()), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
